// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one synchronous single-port memory (1-cycle read latency, word
// addressed) between I-cache refill bursts and single-word D-side accesses.
// An I grant runs a burst of CachedIns reads from a latched base address.
// A D grant issues one read or write. Read data comes back one cycle after
// issue, tagged by owner.
//
// Optional build macro: ARB_ROUND_ROBIN_EN
//   defined     : on a simultaneous IReq/DReq tie, the side not granted last
//                 wins. After reset the last grant counts as D, so I wins the
//                 first tie.
//   not defined : fixed priority, I always wins a tie.
//
// Ports
//   clock, reset           clock; synchronous active-low reset
//   IReq/IAddr/IGnt        I-side refill request, base address, burst grant
//   IValid/IBeat/ILast/IData  refill return: valid, beat index, last beat, data
//   DReq/DWe/DAddr/DWData  D-side request, write enable, address, write data
//   DGnt/DValid/DRData     D-side issue pulse, completion, read data
//   MemEn/MemWe/MemAddr/MemWData/MemRData  single-port memory interface
//
// State table
//   state     | meaning
//   S_IDLE    | arbitrate between requests; memory bus idle
//   S_IBURST  | issue refill beat r_beat at r_base + r_beat
//   S_DACC    | issue the latched D-side access (one cycle)

module mem_port_arbiter #(
   parameter  int dataW     = 32,
   parameter  int CachedIns = 8,
   localparam int BeatW     = $clog2(CachedIns)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             IReq,
   input  logic [dataW-1:0] IAddr,
   output logic             IGnt,
   output logic             IValid,
   output logic [BeatW-1:0] IBeat,
   output logic             ILast,
   output logic [dataW-1:0] IData,
   input  logic             DReq,
   input  logic             DWe,
   input  logic [dataW-1:0] DAddr,
   input  logic [dataW-1:0] DWData,
   output logic             DGnt,
   output logic             DValid,
   output logic [dataW-1:0] DRData,
   output logic             MemEn,
   output logic             MemWe,
   output logic [dataW-1:0] MemAddr,
   output logic [dataW-1:0] MemWData,
   input  logic [dataW-1:0] MemRData
);

   typedef enum logic [1:0] {S_IDLE, S_IBURST, S_DACC} state_t;

   localparam logic [BeatW-1:0] LastBeat = BeatW'(CachedIns - 1);

   state_t             r_state, w_next;
   logic [BeatW-1:0]   r_beat;
   logic [dataW-1:0]   r_base;
   logic [dataW-1:0]   r_daddr;
   logic [dataW-1:0]   r_dwdata;
   logic               r_dwe;
   logic               r_ret_i;
   logic               r_ret_d;
   logic               r_ret_we;
   logic [BeatW-1:0]   r_ret_beat;
   logic               w_ireq;
   logic               w_dreq;
   logic               w_pick_i;
   logic               w_pick_d;

   // A requester still holds its request in the cycle its final response
   // appears, so that stale request must not start a second transaction.
   assign w_ireq = IReq & ~ILast;
   assign w_dreq = DReq & ~DValid;

`ifdef ARB_ROUND_ROBIN_EN
   logic r_last_i;
   assign w_pick_i = w_ireq & (~w_dreq | ~r_last_i);
`else
   assign w_pick_i = w_ireq;
`endif
   assign w_pick_d = w_dreq & ~w_pick_i;

   always_comb begin
      w_next   = r_state;
      IGnt     = 1'b0;
      DGnt     = 1'b0;
      MemEn    = 1'b0;
      MemWe    = 1'b0;
      MemAddr  = '0;
      MemWData = '0;
      case (r_state)
         S_IDLE: begin
            if (w_pick_i)      w_next = S_IBURST;
            else if (w_pick_d) w_next = S_DACC;
         end
         S_IBURST: begin
            IGnt    = 1'b1;
            MemEn   = 1'b1;
            MemAddr = r_base + dataW'(r_beat);
            if (r_beat == LastBeat) w_next = S_IDLE;
         end
         S_DACC: begin
            DGnt     = 1'b1;
            MemEn    = 1'b1;
            MemWe    = r_dwe;
            MemAddr  = r_daddr;
            MemWData = r_dwdata;
            w_next   = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_beat     <= '0;
         r_base     <= '0;
         r_daddr    <= '0;
         r_dwdata   <= '0;
         r_dwe      <= 1'b0;
         r_ret_i    <= 1'b0;
         r_ret_d    <= 1'b0;
         r_ret_we   <= 1'b0;
         r_ret_beat <= '0;
      end else begin
         r_state    <= w_next;
         r_ret_i    <= IGnt;
         r_ret_d    <= DGnt;
         r_ret_we   <= MemWe;
         r_ret_beat <= r_beat;
         if (r_state == S_IBURST)
            r_beat <= (r_beat == LastBeat) ? '0 : r_beat + 1'b1;
         if (r_state == S_IDLE && w_pick_i)
            r_base <= IAddr;
         if (r_state == S_IDLE && w_pick_d) begin
            r_daddr  <= DAddr;
            r_dwdata <= DWData;
            r_dwe    <= DWe;
         end
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   always_ff @(posedge clock) begin
      if (!reset)
         r_last_i <= 1'b0;
      else if (r_state == S_IDLE && w_pick_i)
         r_last_i <= 1'b1;
      else if (r_state == S_IDLE && w_pick_d)
         r_last_i <= 1'b0;
   end
`endif

   assign IValid = r_ret_i;
   assign IBeat  = r_ret_i ? r_ret_beat : '0;
   assign ILast  = r_ret_i && (r_ret_beat == LastBeat);
   assign IData  = r_ret_i ? MemRData : '0;
   assign DValid = r_ret_d;
   // A completed write reports zero data, not whatever the memory drives.
   assign DRData = (r_ret_d && !r_ret_we) ? MemRData : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter with CachedIns=8. The memory model
// returns MemAddr+100 one cycle after a read. Stimulus pushes the expected
// memory issues and the expected returns into queues. A monitor runs on the
// falling edge, pops those queues and compares them with the DUT outputs.
// Honours ARB_ROUND_ROBIN_EN for the expected order on a tie.

module tb_mem_port_arbiter;

   localparam int DW = 32;
   localparam int NB = 8;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          IReq = 1'b0, DReq = 1'b0, DWe = 1'b0;
   logic [DW-1:0] IAddr = '0, DAddr = '0, DWData = '0;
   logic          IGnt, IValid, ILast, DGnt, DValid, MemEn, MemWe;
   logic [2:0]    IBeat;
   logic [DW-1:0] IData, DRData, MemAddr, MemWData;
   logic [DW-1:0] MemRData = '0;

   mem_port_arbiter #(.dataW(DW), .CachedIns(NB)) dut (
      .clock(clock), .reset(reset),
      .IReq(IReq), .IAddr(IAddr), .IGnt(IGnt), .IValid(IValid),
      .IBeat(IBeat), .ILast(ILast), .IData(IData),
      .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWData(DWData),
      .DGnt(DGnt), .DValid(DValid), .DRData(DRData),
      .MemEn(MemEn), .MemWe(MemWe), .MemAddr(MemAddr),
      .MemWData(MemWData), .MemRData(MemRData)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (MemEn === 1'b1 && MemWe === 1'b0) MemRData <= MemAddr + 32'd100;
      else                                  MemRData <= 32'hDEAD_BEEF;
   end

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {bit is_i; bit we; logic [DW-1:0] addr; logic [DW-1:0] wd;} iss_t;
   typedef struct {bit is_i; int beat; bit last; logic [DW-1:0] data;} ret_t;
   iss_t exp_iss[$];
   ret_t exp_ret[$];

   int  checks = 0;
   int  errors = 0;
   bit  mon_en = 0;
   bit  prev_i = 0, prev_d = 0;

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at cycle %0d", n, act, req, cyc);
      end
   endtask

   task automatic push_i(input logic [DW-1:0] base, input int nbeat_iss, input int nbeat_ret);
      for (int k = 0; k < nbeat_iss; k++) begin
         iss_t s;
         s.is_i = 1; s.we = 0; s.addr = base + k; s.wd = '0;
         exp_iss.push_back(s);
      end
      for (int k = 0; k < nbeat_ret; k++) begin
         ret_t r;
         r.is_i = 1; r.beat = k; r.last = (k == NB - 1); r.data = base + k + 100;
         exp_ret.push_back(r);
      end
   endtask

   task automatic push_d(input bit we, input logic [DW-1:0] addr, input logic [DW-1:0] wd);
      iss_t s;
      ret_t r;
      s.is_i = 0; s.we = we; s.addr = addr; s.wd = wd;
      exp_iss.push_back(s);
      r.is_i = 0; r.beat = 0; r.last = 0; r.data = we ? '0 : addr + 100;
      exp_ret.push_back(r);
   endtask

   // Monitor: compares every cycle with the scoreboard queues.
   always @(negedge clock) begin
      if (mon_en) begin
         if (MemEn === 1'b1) begin
            if (exp_iss.size() == 0) chk("unexpected_issue", {MemWe, MemAddr}, 0);
            else begin
               iss_t s;
               s = exp_iss.pop_front();
               chk("issue_owner", {IGnt, DGnt}, s.is_i ? 2'b10 : 2'b01);
               chk("issue_we", MemWe, s.we);
               chk("issue_addr", MemAddr, s.addr);
               if (s.we) chk("issue_wdata", MemWData, s.wd);
            end
         end else
            chk("idle_bus", {IGnt, DGnt, MemWe, MemAddr, MemWData}, 0);
         if (IValid === 1'b1 || DValid === 1'b1) begin
            chk("ret_latency", {prev_i, prev_d}, {IValid, DValid});
            if (exp_ret.size() == 0) chk("unexpected_return", {IValid, DValid}, 0);
            else begin
               ret_t r;
               r = exp_ret.pop_front();
               chk("ret_owner", {IValid, DValid}, r.is_i ? 2'b10 : 2'b01);
               if (r.is_i) begin
                  chk("ibeat", IBeat, r.beat[2:0]);
                  chk("ilast", ILast, r.last);
                  chk("idata", IData, r.data);
               end else
                  chk("drdata", DRData, r.data);
            end
         end
         if (IValid !== 1'b1) chk("i_quiet", {IBeat, ILast, IData}, 0);
         if (DValid !== 1'b1) chk("d_quiet", DRData, 0);
         prev_i = (IGnt === 1'b1);
         prev_d = (DGnt === 1'b1);
      end
   end

   task automatic drain(input string n);
      int t = 0;
      while ((exp_iss.size() != 0 || exp_ret.size() != 0) && t < 60) begin
         @(negedge clock);
         t++;
      end
      chk({n, "_drained"}, exp_iss.size() + exp_ret.size(), 0);
      @(negedge clock);
   endtask

   task automatic wait_gnt(input bit want_i, input string n);
      int t = 0;
      do begin
         @(negedge clock);
         t++;
      end while (!(want_i ? IGnt === 1'b1 : DGnt === 1'b1) && t < 40);
      if (t >= 40) chk({n, "_timeout"}, 1, 0);
   endtask

   initial begin
      repeat (2) @(negedge clock);
      chk("reset_outputs", {IGnt, IValid, IBeat, ILast, IData, DGnt, DValid,
                            DRData, MemEn, MemWe, MemAddr, MemWData}, 0);
      reset = 1'b1;
      prev_i = 0; prev_d = 0;
      mon_en = 1;
      @(negedge clock);
      chk("idle_no_req", {IGnt, DGnt, MemEn}, 0);

      // 1: refill burst at 32
      push_i(32, NB, NB);
      IReq = 1; IAddr = 32;
      wait_gnt(1, "t1");
      IReq = 0;
      drain("t1");

      // 4: tie after an I grant
`ifdef ARB_ROUND_ROBIN_EN
      push_d(0, 20, 0);
      push_i(64, NB, NB);
`else
      push_i(64, NB, NB);
      push_d(0, 20, 0);
`endif
      begin
         int  t = 0;
         bit  gi = 0, gd = 0;
         IReq = 1; IAddr = 64; DReq = 1; DWe = 0; DAddr = 20;
         while (!(gi && gd) && t < 40) begin
            @(negedge clock);
            t++;
            if (IGnt === 1'b1) begin gi = 1; IReq = 0; end
            if (DGnt === 1'b1) begin gd = 1; DReq = 0; end
         end
         chk("t4_both_granted", {gi, gd}, 2'b11);
         IReq = 0; DReq = 0;
      end
      drain("t4");

      // 2: D read
      push_d(0, 5, 0);
      DReq = 1; DWe = 0; DAddr = 5;
      wait_gnt(0, "t2");
      DReq = 0;
      drain("t2");

      // 3: D write
      push_d(1, 9, 69);
      DReq = 1; DWe = 1; DAddr = 9; DWData = 69;
      wait_gnt(0, "t3");
      DReq = 0; DWe = 0; DWData = 0;
      drain("t3");

      // 5: DReq raised at beat 3; D issued two cycles after beat 7
      push_i(32'hFFFF_FFFC, NB, NB);
      push_d(0, 7, 0);
      begin
         int t = 0, li = -1, dg = -1;
         IReq = 1; IAddr = 32'hFFFF_FFFC;
         wait_gnt(1, "t5");
         IReq = 0;
         while (!(IGnt === 1'b1 && MemAddr === 32'hFFFF_FFFF) && t < 20) begin
            @(negedge clock);
            t++;
         end
         DReq = 1; DWe = 0; DAddr = 7;
         t = 0;
         while (dg < 0 && t < 40) begin
            @(negedge clock);
            t++;
            if (IGnt === 1'b1) li = cyc;
            if (DGnt === 1'b1) begin dg = cyc; DReq = 0; end
         end
         chk("t5_d_after_burst_gap", dg - li, 2);
         DReq = 0;
      end
      drain("t5");

      // 6: reset at beat 4 aborts the burst; beat 4 never returns
      push_i(200, 5, 4);
      begin
         int t = 0;
         IReq = 1; IAddr = 200;
         wait_gnt(1, "t6");
         IReq = 0;
         while (!(IGnt === 1'b1 && MemAddr === 32'd204) && t < 20) begin
            @(negedge clock);
            t++;
         end
         reset = 0;
         @(negedge clock);
         chk("t6_reset_outputs", {IGnt, IValid, IBeat, ILast, IData, DGnt, DValid,
                                  DRData, MemEn, MemWe, MemAddr, MemWData}, 0);
         reset = 1;
      end
      drain("t6");

      // recovery after the abort
      push_d(0, 11, 0);
      DReq = 1; DWe = 0; DAddr = 11;
      wait_gnt(0, "t7");
      DReq = 0;
      drain("t7");

      mon_en = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
